riscv_core_me_wb_pipe_reg: RTL and testbench

Parametrised memory-to-writeback (ME->WB) pipeline register stage for the RISC-V core. It registers the ME-stage writeback bundle (alu result, memory data, pc, rd, regwrite, rfwt_sel) and adds a valid/ready handshake, a 2-entry skid buffer for full-throughput backpressure, a synchronous flush, and x0-write suppression. It replaces the per-field combinational ME output logic and feeds the WB stage and the forwarding network.

---
 rtl/riscv_core_me_wb_pipe_reg.sv | 122 ++++++++++++
 tb/tb_riscv_core_me_wb_pipe_reg.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_me_wb_pipe_reg.sv
// ME->WB pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and optional x0-write suppression.
module riscv_core_me_wb_pipe_reg #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RD_W        = 5,
    parameter int unsigned SEL_W       = 2,
    parameter bit          X0_SUPPRESS = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ACT,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_memdat,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_regwrite,
    input  logic [SEL_W-1:0] in_rfwt_sel,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_alu,
    output logic [XLEN-1:0]  out_memdat,
    output logic [XLEN-1:0]  out_pc,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_regwrite,
    output logic [SEL_W-1:0] out_rfwt_sel,
    output logic [1:0]       occupancy
);

    typedef struct packed {
        logic [XLEN-1:0]  alu;
        logic [XLEN-1:0]  memdat;
        logic [XLEN-1:0]  pc;
        logic [RD_W-1:0]  rd;
        logic             regwrite;
        logic [SEL_W-1:0] rfwt_sel;
    } bundle_t;

    bundle_t main_q, skid_q, in_b;
    logic    main_v, skid_v;
    logic    main_v_nxt, skid_v_nxt;
    logic    ld_main_in, ld_main_skid, ld_skid;
    logic    acc, rel;

    always_comb begin
        in_b.alu      = in_alu;
        in_b.memdat   = in_memdat;
        in_b.pc       = in_pc;
        in_b.rd       = in_rd;
        in_b.regwrite = in_regwrite & ~(X0_SUPPRESS && (in_rd == '0));
        in_b.rfwt_sel = in_rfwt_sel;
    end

    // in_ready depends on held state only, so out_ready never reaches it combinationally
    assign in_ready = ~skid_v;
    assign acc      = ACT & in_valid & in_ready & ~flush;
    assign rel      = main_v & out_ready;

    always_comb begin
        main_v_nxt   = main_v;
        skid_v_nxt   = skid_v;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            main_v_nxt = 1'b0;
            skid_v_nxt = 1'b0;
        end else if (!main_v) begin
            if (acc) begin
                main_v_nxt = 1'b1;
                ld_main_in = 1'b1;
            end
        end else if (rel) begin
            // skid entry is older than any new input, so it advances first
            if (skid_v) begin
                ld_main_skid = 1'b1;
                skid_v_nxt   = 1'b0;
            end else if (acc) begin
                ld_main_in = 1'b1;
            end else begin
                main_v_nxt = 1'b0;
            end
        end else if (acc) begin
            ld_skid    = 1'b1;
            skid_v_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_v <= main_v_nxt;
            skid_v <= skid_v_nxt;
            if (ld_main_in) begin
                main_q <= in_b;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= in_b;
            end
        end
    end

    always_comb begin
        out_valid    = main_v;
        out_alu      = main_q.alu;
        out_memdat   = main_q.memdat;
        out_pc       = main_q.pc;
        out_rd       = main_q.rd;
        out_regwrite = main_v & main_q.regwrite;
        out_rfwt_sel = main_q.rfwt_sel;
        occupancy    = {1'b0, main_v} + {1'b0, skid_v};
    end

endmodule

// File: tb/tb_riscv_core_me_wb_pipe_reg.sv
// Bench for riscv_core_me_wb_pipe_reg: directed stimulus feeding a scoreboard queue,
// negedge monitor compares DUT outputs against the queue head.
module tb_riscv_core_me_wb_pipe_reg;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ACT = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_alu = '0, in_memdat = '0, in_pc = '0;
    logic [4:0]  in_rd = '0;
    logic        in_regwrite = 1'b0;
    logic [1:0]  in_rfwt_sel = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_regwrite;
    logic [31:0] out_alu, out_memdat, out_pc;
    logic [4:0]  out_rd;
    logic [1:0]  out_rfwt_sel, occupancy;

    logic        in_ready0, out_valid0, out_regwrite0;
    logic [31:0] out_alu0, out_memdat0, out_pc0;
    logic [4:0]  out_rd0;
    logic [1:0]  out_rfwt_sel0, occupancy0;

    riscv_core_me_wb_pipe_reg #(.XLEN(32), .RD_W(5), .SEL_W(2), .X0_SUPPRESS(1'b1)) u_dut (
        .CLK(CLK), .RST(RST), .ACT(ACT), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_memdat(in_memdat), .in_pc(in_pc), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .in_rfwt_sel(in_rfwt_sel), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu(out_alu),
        .out_memdat(out_memdat), .out_pc(out_pc), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .out_rfwt_sel(out_rfwt_sel), .occupancy(occupancy)
    );

    riscv_core_me_wb_pipe_reg #(.XLEN(32), .RD_W(5), .SEL_W(2), .X0_SUPPRESS(1'b0)) u_dut0 (
        .CLK(CLK), .RST(RST), .ACT(ACT), .in_valid(in_valid), .in_ready(in_ready0),
        .in_alu(in_alu), .in_memdat(in_memdat), .in_pc(in_pc), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .in_rfwt_sel(in_rfwt_sel), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_alu(out_alu0),
        .out_memdat(out_memdat0), .out_pc(out_pc0), .out_rd(out_rd0),
        .out_regwrite(out_regwrite0), .out_rfwt_sel(out_rfwt_sel0), .occupancy(occupancy0)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] alu, memdat, pc;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  sel;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] pc_log[$];
    int          n_chk = 0, n_pass = 0;
    int          max_occ = 0;
    bit          mon_en = 1'b0;
    bit          m_in_ready = 1'b1;
    event        mon_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: compare held state against the scoreboard, then retire on release
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                m_in_ready = (q.size() < 2);
                chk("occupancy", 64'(occupancy), 64'(q.size()));
                chk("in_ready", 64'(in_ready), 64'(m_in_ready));
                chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
                if (q.size() > 0) begin
                    e = q[0];
                    chk("out_alu", 64'(out_alu), 64'(e.alu));
                    chk("out_memdat", 64'(out_memdat), 64'(e.memdat));
                    chk("out_pc", 64'(out_pc), 64'(e.pc));
                    chk("out_rd", 64'(out_rd), 64'(e.rd));
                    chk("out_regwrite", 64'(out_regwrite), 64'(e.rw));
                    chk("out_rfwt_sel", 64'(out_rfwt_sel), 64'(e.sel));
                    if (out_ready) begin
                        pc_log.push_back(e.pc);
                        void'(q.pop_front());
                    end
                end else begin
                    chk("out_regwrite_idle", 64'(out_regwrite), 64'd0);
                end
                if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
                -> mon_done;
            end
        end
    end

    task automatic set_in(input logic [31:0] alu, input logic [31:0] md, input logic [31:0] pc,
                          input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                          input logic exp_rw);
        in_alu = alu; in_memdat = md; in_pc = pc; in_rd = rd;
        in_regwrite = rw; in_rfwt_sel = sel; in_valid = 1'b1;
        cur.alu = alu; cur.memdat = md; cur.pc = pc; cur.rd = rd; cur.rw = exp_rw; cur.sel = sel;
    endtask

    // One clock: stimulus bookkeeping after the monitor, then advance to posedge+1
    task automatic tick(output bit acc);
        @(mon_done);
        acc = 1'b0;
        if (flush) q.delete();
        else if (ACT && in_valid && m_in_ready) begin
            q.push_back(cur);
            acc = 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] rd);
        bit a;
        set_in(pc ^ 32'hA5A5_0000, ~pc, pc, rd, 1'b1, pc[3:2], (rd != 5'd0));
        for (int k = 0; k < 8; k++) begin
            tick(a);
            if (a) break;
        end
        chk("send_accepted", 64'(a), 64'd1);
    endtask

    task automatic drain(input int limit);
        bit a;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < limit && q.size() > 0; k++) tick(a);
        tick(a);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit a;
        int base;
        // reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_regwrite", 64'(out_regwrite), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_alu", 64'(out_alu), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        ACT = 1'b1;
        mon_en = 1'b1;

        // single bundle, 1-cycle latency
        out_ready = 1'b1;
        set_in(32'h1234_5678, 32'hCAFE_0001, 32'h0000_0100, 5'd5, 1'b1, 2'd1, 1'b1);
        tick(a);
        chk("single_accepted", 64'(a), 64'd1);
        in_valid = 1'b0;
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_out_rd", 64'(out_rd), 64'd5);
        chk("single_out_regwrite", 64'(out_regwrite), 64'd1);
        chk("single_out_alu", 64'(out_alu), 64'h1234_5678);
        tick(a);
        chk("single_gone", 64'(out_valid), 64'd0);

        // stream of 8 with out_ready held high
        max_occ = 0;
        base = pc_log.size();
        for (int i = 0; i < 8; i++) send(32'h200 + 32'(4 * i), 5'(i + 1));
        drain(4);
        chk("stream_count", 64'(pc_log.size() - base), 64'd8);
        chk("stream_max_occ", 64'(max_occ), 64'd1);

        // backpressure fills main and skid, third bundle waits upstream
        out_ready = 1'b0;
        base = pc_log.size();
        send(32'h100, 5'd1);
        send(32'h104, 5'd2);
        chk("bp_occupancy", 64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        set_in(32'h108 ^ 32'hA5A5_0000, ~32'h108, 32'h108, 5'd3, 1'b1, 2'd2, 1'b1);
        tick(a);
        chk("bp_third_held", 64'(a), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(a);
            if (a) break;
        end
        chk("bp_third_accepted", 64'(a), 64'd1);
        drain(6);
        chk("bp_count", 64'(pc_log.size() - base), 64'd3);
        if (pc_log.size() - base == 3) begin
            chk("bp_order0", 64'(pc_log[base]), 64'h100);
            chk("bp_order1", 64'(pc_log[base + 1]), 64'h104);
            chk("bp_order2", 64'(pc_log[base + 2]), 64'h108);
        end

        // flush with two held entries and a bundle on the input
        out_ready = 1'b0;
        send(32'h300, 5'd4);
        send(32'h304, 5'd6);
        set_in(32'h308, 32'h0, 32'h308, 5'd7, 1'b1, 2'd0, 1'b1);
        flush = 1'b1;
        tick(a);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush2_out_valid", 64'(out_valid), 64'd0);
        chk("flush2_occupancy", 64'(occupancy), 64'd0);

        // flush with one held entry while in_ready=1: input still dropped
        send(32'h310, 5'd8);
        set_in(32'h314, 32'h0, 32'h314, 5'd9, 1'b1, 2'd0, 1'b1);
        flush = 1'b1;
        tick(a);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush1_occupancy", 64'(occupancy), 64'd0);

        // ACT=0 blocks acceptance
        ACT = 1'b0;
        out_ready = 1'b1;
        set_in(32'h320, 32'h0, 32'h320, 5'd10, 1'b1, 2'd0, 1'b1);
        tick(a);
        tick(a);
        chk("act0_occupancy", 64'(occupancy), 64'd0);
        chk("act0_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        ACT = 1'b1;

        // x0 write suppression versus non-suppressing instance
        set_in(32'h0BAD_0000, 32'h1, 32'h400, 5'd0, 1'b1, 2'd3, 1'b0);
        tick(a);
        in_valid = 1'b0;
        chk("x0_out_valid", 64'(out_valid), 64'd1);
        chk("x0_regwrite_sup", 64'(out_regwrite), 64'd0);
        chk("x0_regwrite_nosup", 64'(out_regwrite0), 64'd1);
        drain(4);

        // asynchronous reset while holding two entries
        out_ready = 1'b0;
        send(32'h500, 5'd11);
        send(32'h504, 5'd12);
        in_valid = 1'b0;
        mon_en = 1'b0;
        RST = 1'b0;
        #2;
        chk("arst_occupancy", 64'(occupancy), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_pc", 64'(out_pc), 64'd0);
        q.delete();
        @(posedge CLK); #1;
        RST = 1'b1;
        mon_en = 1'b1;
        out_ready = 1'b1;
        send(32'h600, 5'd13);
        drain(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
